alu_result_fifo: RTL and testbench



---
 rtl/alu_result_fifo.sv | 89 ++++++++
 tb/tb_alu_result_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for tagged ALU results, with a saturating
// counter of results rejected while the buffer is full.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int OPW   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  input  logic [OPW-1:0]           in_op,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [OPW-1:0]           out_op,
  output logic                     out_zero,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = OPW + DW;

  // Handshake: a word moves on a rising edge only when its valid and ready
  // are both high in the cycle before that edge.
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic          push, pop, drop;
  logic [EW-1:0] head;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign drop_cnt  = drop_q;

  assign push = in_valid && !full;
  assign pop  = !empty && out_ready;
  assign drop = in_valid && full;

  assign head     = mem_q[rd_ptr_q];
  assign out_data = empty ? '0 : head[DW-1:0];
  assign out_op   = empty ? '0 : head[EW-1:DW];
  assign out_zero = out_valid && (out_data == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // Clear takes priority over a coincident drop.
    if (clr_drop)                    drop_d = 8'd0;
    else if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= {in_op, in_data};
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed and randomized checks of alu_result_fifo against a queue-based
// model of the buffer contents and the drop counter.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int OPW   = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [DW-1:0]  in_data;
  logic [OPW-1:0] in_op;
  logic           in_ready;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [OPW-1:0] out_op;
  logic           out_zero;
  logic           out_ready;
  logic [2:0]     count;
  logic           full;
  logic           empty;
  logic [7:0]     drop_cnt;
  logic           clr_drop;

  int vectors     = 0;
  int miscompares = 0;

  logic [OPW+DW-1:0] exp_q[$];
  int                drop_m;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH), .DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_op(in_op), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_op(out_op),
    .out_zero(out_zero), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .clr_drop(clr_drop)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [OPW+DW-1:0] h;
    int n;
    n = exp_q.size();
    h = (n > 0) ? exp_q[0] : '0;
    chk({tag, ".count"},     32'(count),     32'(n));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(n < DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(n > 0));
    chk({tag, ".out_data"},  32'(out_data),  32'(h[DW-1:0]));
    chk({tag, ".out_op"},    32'(out_op),    32'(h[OPW+DW-1:DW]));
    chk({tag, ".out_zero"},  32'(out_zero),  32'(n > 0 && h[DW-1:0] == 0));
    chk({tag, ".full"},      32'(full),      32'(n == DEPTH));
    chk({tag, ".empty"},     32'(empty),     32'(n == 0));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(drop_m));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(logic v, logic [DW-1:0] d, logic [OPW-1:0] op,
                      logic ordy, logic clr, logic r, string tag);
    bit was_full, was_empty;
    in_valid  = v;
    in_data   = d;
    in_op     = op;
    out_ready = ordy;
    clr_drop  = clr;
    rst       = r;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      drop_m = 0;
    end else begin
      if (!was_empty && ordy) void'(exp_q.pop_front());
      if (v && !was_full) exp_q.push_back({op, d});
      if (clr) drop_m = 0;
      else if (v && was_full && drop_m < 255) drop_m++;
    end
    @(negedge clk);
    rst = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] wrap_seq [10];
    drop_m = 0;
    in_valid = 0; in_data = '0; in_op = '0; out_ready = 0; clr_drop = 0; rst = 1;

    // Reset with junk inputs present; outputs must show reset values.
    step(1, 8'hFF, 3'd7, 1, 0, 1, "rst0");
    step(0, 8'h00, 3'd0, 0, 0, 1, "rst1");
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.empty",    32'(empty),    32'd1);

    // Three tagged pushes, then drain in order.
    step(1, 8'h0C, 3'b000, 0, 0, 0, "p1");
    step(1, 8'h00, 3'b010, 0, 0, 0, "p2");
    step(1, 8'hF1, 3'b101, 0, 0, 0, "p3");
    chk("p3.count", 32'(count), 32'd3);
    chk("p3.head",  32'(out_data), 32'h0C);
    step(0, 8'h00, 3'd0, 1, 0, 0, "d1");
    chk("d1.zero", 32'(out_zero), 32'd1);
    step(0, 8'h00, 3'd0, 1, 0, 0, "d2");
    chk("d2.head", 32'({out_op, out_data}), 32'({3'b101, 8'hF1}));
    step(0, 8'h00, 3'd0, 1, 0, 0, "d3");
    chk("d3.data", 32'(out_data), 32'd0);

    // Fill, then three rejected pushes.
    for (int i = 0; i < DEPTH; i++) step(1, 8'hA0 + 8'(i), 3'(i), 0, 0, 0, "fill");
    for (int i = 0; i < 3; i++) step(1, 8'hEE, 3'd6, 0, 0, 0, "ovf");
    chk("ovf.drop", 32'(drop_cnt), 32'd3);
    chk("ovf.head", 32'(out_data), 32'hA0);
    step(0, 8'h00, 3'd0, 0, 1, 0, "clr");

    // Two pops leave A2,A3; then ten push+pop cycles through the wrap point.
    step(0, 8'h00, 3'd0, 1, 0, 0, "pop2a");
    step(0, 8'h00, 3'd0, 1, 0, 0, "pop2b");
    wrap_seq[0] = 8'hA2;
    wrap_seq[1] = 8'hA3;
    for (int i = 2; i < 10; i++) wrap_seq[i] = 8'h10 + 8'(i - 2);
    for (int i = 0; i < 10; i++) begin
      chk("wrap.head", 32'(out_data), 32'(wrap_seq[i]));
      step(1, 8'h10 + 8'(i), 3'(i), 1, 0, 0, "wrap");
      chk("wrap.count", 32'(count), 32'd2);
    end

    // Saturate drop_cnt, then clear coinciding with a drop.
    step(1, 8'h33, 3'd1, 0, 0, 0, "top1");
    step(1, 8'h34, 3'd2, 0, 0, 0, "top2");
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), 3'($urandom), 0, 0, 0, "sat");
    chk("sat.drop", 32'(drop_cnt), 32'd255);
    step(1, 8'h77, 3'd3, 0, 1, 0, "clrdrop");
    chk("clrdrop.drop", 32'(drop_cnt), 32'd0);

    // Reset at count=3 with a push and pop in flight.
    step(0, 8'h00, 3'd0, 1, 0, 0, "to3");
    step(1, 8'h99, 3'd4, 1, 0, 1, "midrst");
    chk("midrst.count", 32'(count), 32'd0);
    step(1, 8'h2A, 3'd5, 0, 0, 0, "post");
    chk("post.head", 32'({out_op, out_data}), 32'({3'd5, 8'h2A}));
    chk("post.count", 32'(count), 32'd1);

    // Full with a pop: push is still refused, no pass-through.
    for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 3'(i), 0, 0, 0, "refill");
    step(1, 8'h55, 3'd2, 1, 0, 0, "fullpop");
    chk("fullpop.count", 32'(count), 32'd3);
    chk("fullpop.drop",  32'(drop_cnt), 32'd1);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
